// File: rtl/instr_encoder.sv
// Two-stage RISC-V instruction encoder: packs decoded fields and an immediate into a
// 32-bit instruction word and flags immediates the format cannot represent.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [7:0]  err_count
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 7;
  localparam int unsigned REGW = 5;
  localparam int unsigned F3W  = 3;
  localparam int unsigned F7W  = 7;
  localparam int unsigned ENCW = 16;
  localparam int unsigned ERRW = 8;

  localparam logic [OPW-1:0] OP_R     = 7'b0110011;
  localparam logic [OPW-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPW-1:0] OP_IMM   = 7'b0010011;
  localparam logic [OPW-1:0] OP_JALR  = 7'b1100111;
  localparam logic [OPW-1:0] OP_STORE = 7'b0100011;
  localparam logic [OPW-1:0] OP_BR    = 7'b1100011;
  localparam logic [OPW-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OPW-1:0] OP_AUIPC = 7'b0010111;
  localparam logic [OPW-1:0] OP_JAL   = 7'b1101111;
  localparam logic [XLEN-1:0] NOP     = 32'h0000_0013;

  logic            s1_valid_q, s1_valid_d;
  logic            s1_err_q;
  logic [OPW-1:0]  s1_op_q;
  logic [REGW-1:0] s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [F3W-1:0]  s1_f3_q;
  logic [F7W-1:0]  s1_f7_q;
  logic [XLEN-1:0] s1_imm_q;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_instr_q, out_instr_d;
  logic            out_err_q, out_err_d;
  logic [ENCW-1:0] enc_count_q, enc_count_d;
  logic [ERRW-1:0] err_count_q, err_count_d;

  logic            range_err_c;
  logic [XLEN-1:0] pack_c;
  logic            s2_load, accept, deliver;

  // Range check on the incoming immediate, registered alongside the fields
  always_comb begin
    range_err_c = 1'b1;
    case (in_opcode)
      OP_R: range_err_c = 1'b0;
      OP_LOAD, OP_IMM, OP_JALR, OP_STORE:
        range_err_c = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      OP_BR:
        range_err_c = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      OP_LUI, OP_AUIPC:
        range_err_c = |in_imm[11:0];
      OP_JAL:
        range_err_c = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      default: range_err_c = 1'b1;
    endcase
  end

  // Format packer; out-of-range immediates are packed from their truncated bits
  always_comb begin
    pack_c = NOP;
    case (s1_op_q)
      OP_R:
        pack_c = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      OP_LOAD, OP_IMM, OP_JALR:
        pack_c = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      OP_STORE:
        pack_c = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], s1_op_q};
      OP_BR:
        pack_c = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                  s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      OP_LUI, OP_AUIPC:
        pack_c = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
      OP_JAL:
        pack_c = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                  s1_rd_q, s1_op_q};
      default: pack_c = NOP;
    endcase
  end

  // Pipeline control and next-state
  always_comb begin
    s2_load     = s1_valid_q & (~out_valid_q | out_ready);
    in_ready    = ~s1_valid_q | s2_load;
    accept      = in_valid & in_ready;
    deliver     = out_valid_q & out_ready;
    s1_valid_d  = accept | (s1_valid_q & ~s2_load);
    out_valid_d = s2_load | (out_valid_q & ~out_ready);
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (s2_load) begin
      out_instr_d = pack_c;
      out_err_d   = s1_err_q;
    end
    if (deliver) begin
      enc_count_d = enc_count_q + ENCW'(1);
      if (out_err_q && (err_count_q != {ERRW{1'b1}})) begin
        err_count_d = err_count_q + ERRW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_op_q     <= '0;
      s1_rd_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_f3_q     <= '0;
      s1_f7_q     <= '0;
      s1_imm_q    <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
      if (accept) begin
        s1_err_q <= range_err_c;
        s1_op_q  <= in_opcode;
        s1_rd_q  <= in_rd;
        s1_rs1_q <= in_rs1;
        s1_rs2_q <= in_rs2;
        s1_f3_q  <= in_funct3;
        s1_f7_q  <= in_funct7;
        s1_imm_q <= in_imm;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed table plus hand-written sequences for the instr_encoder pipeline:
// formats, range errors, backpressure, streaming, counter saturation and mid-flight reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;

  instr_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic [31:0] ei, input logic ee);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.exp_instr = ei; v.exp_err = ee;
    return v;
  endfunction

  // Reference packer written bit-slice by bit-slice from the format tables
  function automatic logic [31:0] gold(input vec_t v);
    logic [31:0] w;
    w = 32'd0;
    w[6:0] = v.op;
    case (v.op)
      7'h33: begin
        w[11:7] = v.rd; w[14:12] = v.f3; w[19:15] = v.rs1; w[24:20] = v.rs2; w[31:25] = v.f7;
      end
      7'h03, 7'h13, 7'h67: begin
        w[11:7] = v.rd; w[14:12] = v.f3; w[19:15] = v.rs1; w[31:20] = v.imm[11:0];
      end
      7'h23: begin
        w[11:7] = v.imm[4:0]; w[14:12] = v.f3; w[19:15] = v.rs1; w[24:20] = v.rs2;
        w[31:25] = v.imm[11:5];
      end
      7'h63: begin
        w[7] = v.imm[11]; w[11:8] = v.imm[4:1]; w[14:12] = v.f3; w[19:15] = v.rs1;
        w[24:20] = v.rs2; w[30:25] = v.imm[10:5]; w[31] = v.imm[12];
      end
      7'h37, 7'h17: begin
        w[11:7] = v.rd; w[31:12] = v.imm[31:12];
      end
      7'h6F: begin
        w[11:7] = v.rd; w[19:12] = v.imm[19:12]; w[20] = v.imm[11];
        w[30:21] = v.imm[10:1]; w[31] = v.imm[20];
      end
      default: w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  function automatic logic gold_err(input vec_t v);
    logic signed [31:0] s;
    s = v.imm;
    case (v.op)
      7'h33:                      return 1'b0;
      7'h03, 7'h13, 7'h67, 7'h23: return (s < -2048) || (s > 2047);
      7'h63:                      return (s < -4096) || (s > 4095) || v.imm[0];
      7'h37, 7'h17:               return v.imm[11:0] != 12'd0;
      7'h6F:                      return (s < -(32'sd1 <<< 20)) || (s > ((32'sd1 <<< 20) - 1)) || v.imm[0];
      default:                    return 1'b1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
    in_valid  = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t        bp [3];
  vec_t        rv;
  logic [6:0]  ops [9];
  logic [32:0] expq [$];
  logic [32:0] e;
  logic [31:0] r;
  int          errs, acc, seen, first_c, last_c;

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;

    vecs[0]  = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0005, 32'h0050_0093, 1'b0);
    vecs[1]  = mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h0000_0008, 32'h0020_A423, 1'b0);
    vecs[2]  = mk(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    vecs[3]  = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    vecs[4]  = mk(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    vecs[5]  = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h8000_0093, 1'b1);
    vecs[6]  = mk(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0003, 32'h0000_0163, 1'b1);
    vecs[7]  = mk(7'h7F, 5'd5, 5'd3, 5'd0, 3'd7, 7'h00, 32'h0000_0000, 32'h0000_0013, 1'b1);
    vecs[8]  = mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0);
    vecs[9]  = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
    vecs[10] = mk(7'h17, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0001, 32'h0000_0017, 1'b1);
    vecs[11] = mk(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF0_0000, 32'h8000_006F, 1'b0);
    vecs[12] = mk(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, 32'h8000_006F, 1'b1);

    bp[0] = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1, 32'h0010_0093, 1'b0);
    bp[1] = mk(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2, 32'h0020_0113, 1'b0);
    bp[2] = mk(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3, 32'h0030_0193, 1'b0);

    ops[0] = 7'h33; ops[1] = 7'h03; ops[2] = 7'h13; ops[3] = 7'h67; ops[4] = 7'h23;
    ops[5] = 7'h63; ops[6] = 7'h37; ops[7] = 7'h17; ops[8] = 7'h6F;

    // Reset state
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_enc_count", 32'(enc_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table: one bundle at a time, exact two-cycle latency
    errs = 0;
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1 check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d_early_valid", i), 32'(out_valid), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_instr", i), out_instr, vecs[i].exp_instr);
      check($sformatf("v%0d_err", i), 32'(out_err), 32'(vecs[i].exp_err));
      if (vecs[i].exp_err) errs++;
      @(negedge clk);
      check($sformatf("v%0d_enc_count", i), 32'(enc_count), 32'(i + 1));
      check($sformatf("v%0d_err_count", i), 32'(err_count), 32'(errs));
    end

    // Backpressure: three bundles offered while the consumer stalls
    do_reset();
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (acc < 3) apply(bp[acc]); else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) acc++;
    end
    check("bp_accepts", 32'(acc), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_instr", out_instr, bp[0].exp_instr);
    seen = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (acc < 3) apply(bp[acc]); else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        if (seen < 3) check($sformatf("bp_word%0d", seen), out_instr, bp[seen].exp_instr);
        if (first_c < 0) first_c = c;
        last_c = c;
        seen++;
      end
      if (in_valid && in_ready) acc++;
    end
    check("bp_words", 32'(seen), 32'd3);
    check("bp_consecutive", 32'(last_c - first_c), 32'd2);
    check("bp_enc_count", 32'(enc_count), 32'd3);

    // Streaming: 20 random bundles, one per cycle
    do_reset();
    seen = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c < 20) begin
        r = $urandom;
        rv.op  = ops[$urandom_range(0, 8)];
        rv.rd  = 5'($urandom); rv.rs1 = 5'($urandom); rv.rs2 = 5'($urandom);
        rv.f3  = 3'($urandom); rv.f7  = 7'($urandom);
        rv.imm = r[0] ? {{20{r[31]}}, r[31:20]} : $urandom;
        rv.exp_instr = 32'd0; rv.exp_err = 1'b0;
        apply(rv);
        expq.push_back({gold_err(rv), gold(rv)});
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 20) check($sformatf("st%0d_in_ready", c), 32'(in_ready), 32'd1);
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("st_extra_word", 32'(out_valid), 32'd0);
        end else begin
          e = expq.pop_front();
          check($sformatf("st%0d_instr", seen), out_instr, e[31:0]);
          check($sformatf("st%0d_err", seen), 32'(out_err), 32'(e[32]));
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        seen++;
      end
    end
    check("st_words", 32'(seen), 32'd20);
    check("st_consecutive", 32'(last_c - first_c), 32'd19);
    check("st_first_latency", 32'(first_c), 32'd2);
    check("st_enc_count", 32'(enc_count), 32'd20);

    // err_count saturation: 260 unknown-opcode words
    do_reset();
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      apply(vecs[7]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_err_count", 32'(err_count), 32'hFF);
    check("sat_enc_count", 32'(enc_count), 32'd260);

    // Reset with two words in flight
    out_ready = 1'b0;
    @(negedge clk);
    apply(vecs[0]);
    @(negedge clk);
    apply(vecs[1]);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("mf_pre_valid", 32'(out_valid), 32'd1);
    check("mf_pre_in_ready", 32'(in_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("mf_valid", 32'(out_valid), 32'd0);
    check("mf_enc_count", 32'(enc_count), 32'd0);
    check("mf_err_count", 32'(err_count), 32'd0);
    check("mf_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mf_idle_words", 32'(seen), 32'd0);
    @(negedge clk);
    apply(vecs[3]);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        seen++;
        check("mf_word", out_instr, vecs[3].exp_instr);
      end
    end
    check("mf_words", 32'(seen), 32'd1);
    check("mf_enc_after", 32'(enc_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RISC-V instruction encoder, the inverse of the ID-stage immediate decode. It takes decoded fields (opcode, registers, funct codes, a full 32-bit immediate) and packs them into a 32-bit instruction word for the selected format. It flags any immediate the format cannot represent. It sits in front of the instruction-memory loader and the self-test stimulus path, with valid/ready handshakes on both sides.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- in_opcode  in  7  selects the format.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3; in_funct7  in  7  function fields.
- in_imm  in  32  immediate as a signed or upper value, unshifted byte offset.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded instruction.
- out_err  out  1  immediate not representable or opcode unknown; qualified by out_valid.
- enc_count  out  16  count of words delivered (out_valid & out_ready); wraps.
- err_count  out  8  count of delivered words with out_err=1; saturates at 0xFF.

## Operation
- Stage 1 (S1) registers the fields. The range check is computed combinationally from the inputs and registered as s1_err.
- Stage 2 (S2) registers the packed word and the error flag. S2 drives out_instr and out_err directly from flops.
- The format is chosen by in_opcode:
  - R (0110011): {funct7, rs2, rs1, funct3, rd, op}. The immediate is ignored and is never an error.
  - I (0000011, 0010011, 1100111): {imm[11:0], rs1, funct3, rd, op}. Error unless imm[31:11] are all equal.
  - S (0100011): {imm[11:5], rs2, rs1, funct3, imm[4:0], op}. Same range rule as I.
  - B (1100011): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}. Error unless imm[31:12] are all equal and imm[0]=0.
  - U (0110111, 0010111): {imm[31:12], rd, op}. Error unless imm[11:0]=0.
  - J (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}. Error unless imm[31:20] are all equal and imm[0]=0.
  - Any other opcode: out_instr = 0x00000013 (NOP) and out_err=1.
- On a range error the word is still packed from the truncated bits. Only out_err marks it.
- Fields not used by a format are ignored.

## Timing
- Reset values: out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0, S1 valid=0. in_ready is 1 out of reset, since it is combinational from the empty pipeline.
- Latency: a bundle accepted in cycle N (in_valid & in_ready) gives out_valid=1 in cycle N+2 when there is no backpressure.
- Throughput: one word per cycle while out_ready=1.
- Pipeline control:
  - s2_load = s1_valid & (!out_valid | out_ready).
  - in_ready = !s1_valid | s2_load.
  - There is no combinational path from any in_* signal to any out_* signal.
- Backpressure: while out_ready=0 and out_valid=1, S2 holds. S1 fills once, then in_ready=0. At most 2 words are in flight, with no loss or reordering.
- Output stability: once out_valid=1, out_instr and out_err stay constant until the handshake completes.
- Counters:
  - enc_count increments on out_valid & out_ready and wraps from 0xFFFF to 0.
  - err_count increments on the same event when out_err=1, and stops at 0xFF.
- Simultaneous events: a handshake on both sides in the same cycle is legal. S1 passes its bundle to S2 while taking the new one.
- Reset mid-operation: all in-flight words are discarded immediately (asynchronous). No out_valid is asserted until a new bundle is accepted after rst deasserts.

## Test plan
- Basic I-type and S-type: encode addi x1,x0,5 (op 0010011, imm 5), then sw x2,8(x1) (op 0100011, f3 010). Outputs must be 0x00500093, then 0x0020A423, each 2 cycles after its accept, with out_err=0.
- Branch, jump and upper formats:
  - beq x0,x0,-4 (imm 0xFFFFFFFC) must give 0xFE000EE3.
  - jal x1,+2048 (imm 0x800) must give 0x001000EF.
  - lui x5 with imm 0x12345000 must give 0x123452B7.
- Range errors:
  - addi x1,x0 with imm 2048 must give 0x80000093, out_err=1, err_count=1.
  - beq with imm 3 must give out_err=1.
  - opcode 0x7F must give 0x00000013 with out_err=1.
- Backpressure: hold out_ready=0 and offer 3 back-to-back bundles.
  - in_ready must drop after 2 accepts.
  - On releasing out_ready, the 3 words must appear in order on consecutive cycles, and enc_count must be 3.
- Streaming: 20 random valid bundles with in_valid and out_ready held high.
  - One word per cycle, all matching the golden packer.
  - enc_count must be 20 after the final handshake.
- Reset mid-flight: assert rst with 2 words in flight.
  - out_valid, enc_count and err_count must go to 0 at once.
  - The next accept must produce exactly one word.
